// File: rtl/bit_length_scan_pkg.sv
// Shared types and sizing helpers for the bit-length scanner.
// Imported by the priority encoder and the scanner top.
package bitlen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic MODE_MSB = 1'b0;
  localparam logic MODE_LSB = 1'b1;

  function automatic int chunk_cnt(int w, int s);
    return w / s;
  endfunction

  function automatic int ptr_width(int nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

endpackage

// File: rtl/bit_length_scan_prio_enc.sv
// STEP-wide priority encoder, highest-first or lowest-first.
// Purely combinational; hit flags a non-zero chunk.
module bit_prio_enc
  import bitlen_pkg::*;
#(
  parameter int STEP = 4,
  parameter int PW   = (STEP > 1) ? $clog2(STEP) : 1
) (
  input  logic [STEP-1:0] data_i,
  input  logic            lsb_first_i,
  output logic [PW-1:0]   pos_o,
  output logic            hit_o
);

  always_comb begin
    pos_o = '0;
    hit_o = |data_i;
    if (lsb_first_i == MODE_MSB) begin
      for (int i = 0; i < STEP; i++)
        if (data_i[i]) pos_o = PW'(i);
    end else begin
      for (int i = STEP - 1; i >= 0; i--)
        if (data_i[i]) pos_o = PW'(i);
    end
  end

endmodule

// File: rtl/bit_length_scan.sv
// Multi-cycle leading/trailing-one locator, STEP bits per cycle.
// Exits early on the first non-zero chunk; flags all-zero operands.
module bit_length_scan
  import bitlen_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 4,
  parameter int LW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic             ready,
  output logic             done,
  output logic [LW-1:0]    length,
  output logic             zero
);

  localparam int NC   = chunk_cnt(WIDTH, STEP);
  localparam int PTRW = ptr_width(NC);
  localparam int PW   = (STEP > 1) ? $clog2(STEP) : 1;

  if (WIDTH % STEP != 0) begin : g_bad_div
    $error("WIDTH must be a multiple of STEP");
  end
  if ((STEP & (STEP - 1)) != 0) begin : g_bad_pow2
    $error("STEP must be a power of two");
  end

  state_e              state_q;
  logic [WIDTH-1:0]    op_q;
  logic                mode_q;
  logic [PTRW-1:0]     ptr_q;
  logic                done_q;
  logic [LW-1:0]       len_q;
  logic                zero_q;

  logic [NC-1:0][STEP-1:0] chunks;
  logic [STEP-1:0]     chunk;
  logic [PW-1:0]       pos;
  logic                hit;
  logic                last;
  logic [PTRW-1:0]     ptr_d;
  logic [LW-1:0]       len_d;
  int                  idx;

  assign chunks = op_q;
  assign chunk  = chunks[ptr_q];

  bit_prio_enc #(
    .STEP (STEP),
    .PW   (PW)
  ) u_enc (
    .data_i      (chunk),
    .lsb_first_i (mode_q),
    .pos_o       (pos),
    .hit_o       (hit)
  );

  always_comb begin
    idx   = int'(ptr_q) * STEP + int'(pos);
    len_d = idx[LW-1:0];
    if (mode_q == MODE_MSB) begin
      last  = (ptr_q == '0);
      ptr_d = ptr_q - PTRW'(1);
    end else begin
      last  = (ptr_q == PTRW'(NC - 1));
      ptr_d = ptr_q + PTRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= '0;
      mode_q  <= MODE_MSB;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      len_q   <= '1;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= in;
            mode_q  <= mode;
            ptr_q   <= (mode == MODE_MSB) ? PTRW'(NC - 1) : '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            len_q   <= len_d;
            zero_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (last) begin
            len_q   <= '1;
            zero_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            ptr_q <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign length = len_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bit_length_scan.sv
// Directed + random bench for bit_length_scan at STEP=4, 1 and 64.
// Expected results queue on start and are checked when done fires.
module tb_bit_length_scan;

  localparam int NDUT = 3;
  localparam int STEPS [NDUT] = '{4, 1, 64};
  localparam int NCS   [NDUT] = '{16, 64, 1};

  typedef struct {
    logic [5:0] len;
    logic       zero;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        st   [NDUT];
  logic        md   [NDUT];
  logic [63:0] din  [NDUT];
  logic        rdy  [NDUT];
  logic        dn   [NDUT];
  logic [5:0]  len  [NDUT];
  logic        zr   [NDUT];

  exp_t sbq[$];
  int   nvec;
  int   nerr;

  bit_length_scan #(.WIDTH(64), .STEP(4)) u_s4 (
    .clk(clk), .rstn(rstn), .start(st[0]), .mode(md[0]),
    .in(din[0]), .ready(rdy[0]), .done(dn[0]),
    .length(len[0]), .zero(zr[0])
  );

  bit_length_scan #(.WIDTH(64), .STEP(1)) u_s1 (
    .clk(clk), .rstn(rstn), .start(st[1]), .mode(md[1]),
    .in(din[1]), .ready(rdy[1]), .done(dn[1]),
    .length(len[1]), .zero(zr[1])
  );

  bit_length_scan #(.WIDTH(64), .STEP(64)) u_s64 (
    .clk(clk), .rstn(rstn), .start(st[2]), .mode(md[2]),
    .in(din[2]), .ready(rdy[2]), .done(dn[2]),
    .length(len[2]), .zero(zr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(int d, logic m, logic [63:0] v);
    exp_t e;
    int   idx;
    int   k;
    idx = -1;
    if (m == 1'b0) begin
      for (int i = 0; i < 64; i++)
        if (v[i]) idx = i;
    end else begin
      for (int i = 63; i >= 0; i--)
        if (v[i]) idx = i;
    end
    if (idx < 0) begin
      e.len  = 6'h3F;
      e.zero = 1'b1;
      e.cyc  = NCS[d];
    end else begin
      k      = idx / STEPS[d];
      e.len  = idx[5:0];
      e.zero = 1'b0;
      e.cyc  = m ? k + 1 : NCS[d] - k;
    end
    return e;
  endfunction

  task automatic run_op(int d, logic m, logic [63:0] v, bit poke);
    exp_t  e;
    int    cnt;
    string t;
    t = $sformatf("d%0d m%0d v%h", d, m, v);
    @(negedge clk);
    md[d]  = m;
    din[d] = v;
    st[d]  = 1'b1;
    sbq.push_back(model(d, m, v));
    @(posedge clk);
    #1 st[d] = 1'b0;
    chk({t, " ready_drop"}, 64'(rdy[d]), 64'd0);
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      #1 cnt++;
      if (dn[d]) break;
      if (poke && cnt == 3) begin
        st[d]  = 1'b1;
        din[d] = ~v;
        md[d]  = ~m;
      end
      if (poke && cnt == 4) st[d] = 1'b0;
    end
    e = sbq.pop_front();
    chk({t, " done_seen"}, 64'(dn[d]), 64'd1);
    chk({t, " length"}, 64'(len[d]), 64'(e.len));
    chk({t, " zero"}, 64'(zr[d]), 64'(e.zero));
    chk({t, " cycles"}, 64'(cnt), 64'(e.cyc));
    chk({t, " ready_done"}, 64'(rdy[d]), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          saw;
    logic        m;
    logic [63:0] r;
    logic [63:0] v;
    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      st[i]  = 1'b0;
      md[i]  = 1'b0;
      din[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("rst_ready d%0d", i), 64'(rdy[i]), 64'd1);
      chk($sformatf("rst_done d%0d", i), 64'(dn[i]), 64'd0);
      chk($sformatf("rst_len d%0d", i), 64'(len[i]), 64'h3F);
      chk($sformatf("rst_zero d%0d", i), 64'(zr[i]), 64'd0);
    end

    // Directed STEP=4 cases, issued back-to-back in done cycles.
    run_op(0, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    run_op(0, 1'b0, 64'h1, 1'b0);
    run_op(0, 1'b1, 64'h0000_0000_0001_0000, 1'b0);
    run_op(0, 1'b1, 64'hF000_0000_0000_0008, 1'b0);
    run_op(0, 1'b0, 64'h0, 1'b0);
    run_op(0, 1'b1, 64'h0, 1'b0);
    run_op(0, 1'b0, 64'h100, 1'b0);

    @(posedge clk);
    #1 chk("done_width", 64'(dn[0]), 64'd0);
    chk("hold_len", 64'(len[0]), 64'd8);
    repeat (3) @(posedge clk);
    #1 chk("hold_len2", 64'(len[0]), 64'd8);
    chk("hold_zero", 64'(zr[0]), 64'd0);

    run_op(0, 1'b0, 64'h1, 1'b1);
    run_op(0, 1'b0, 64'h0, 1'b0);

    // Reset during the third cycle of a 16-cycle scan.
    @(negedge clk);
    md[0]  = 1'b0;
    din[0] = 64'h0;
    st[0]  = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("midrst_ready", 64'(rdy[0]), 64'd1);
    chk("midrst_len", 64'(len[0]), 64'h3F);
    chk("midrst_zero", 64'(zr[0]), 64'd0);
    chk("midrst_done", 64'(dn[0]), 64'd0);
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (dn[0]) saw = 1'b1;
    end
    chk("midrst_no_done", 64'(saw), 64'd0);
    run_op(0, 1'b0, 64'h4, 1'b0);

    // Random sweep across all three configurations.
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 12; n++) begin
        m = 1'($urandom_range(1, 0));
        r = {$urandom, $urandom};
        if ($urandom_range(7, 0) == 0)
          v = '0;
        else if (m == 1'b0)
          v = r >> $urandom_range(63, 0);
        else
          v = r << $urandom_range(63, 0);
        run_op(d, m, v, 1'b0);
      end
      run_op(d, 1'b0, 64'h0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
